h14tx_period_scheduler: RTL



---
 rtl/h14tx_period_scheduler_if.sv | 29 ++
 rtl/h14tx_period_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/h14tx_period_scheduler_if.sv
// Period-scheduler bundle: timing/request inputs from the video timing source,
// period/encoder-select outputs towards the TERC4/TMDS/guard encoders.
interface h14tx_period_scheduler_if;
  logic        video_next;
  logic        de_next;
  logic [11:0] blank_remaining;
  logic        island_req;
  logic [4:0]  island_len;
  logic [2:0]  period;
  logic [3:0]  ctl;
  logic        guard_active;
  logic        guard_switch;
  logic        island_ack;
  logic        packet_start;
  logic [4:0]  packet_index;
  logic        overrun;

  modport master (
    output video_next, de_next, blank_remaining, island_req, island_len,
    input  period, ctl, guard_active, guard_switch, island_ack,
           packet_start, packet_index, overrun
  );

  modport slave (
    input  video_next, de_next, blank_remaining, island_req, island_len,
    output period, ctl, guard_active, guard_switch, island_ack,
           packet_start, packet_index, overrun
  );
endinterface

// File: rtl/h14tx_period_scheduler.sv
// HDMI 1.4 TX period sequencer: control / video preamble+guard+active /
// data-island preamble+guards+packets, one decision per TMDS character clock.
module h14tx_period_scheduler #(
  parameter int MinGap     = 4,
  parameter int MaxPackets = 18
) (
  input logic                     clk,
  input logic                     rst,
  h14tx_period_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    P_CTRL   = 3'd0,
    P_VPRE   = 3'd1,
    P_VGUARD = 3'd2,
    P_VACT   = 3'd3,
    P_IPRE   = 3'd4,
    P_IGL    = 3'd5,
    P_IDATA  = 3'd6,
    P_IGT    = 3'd7
  } period_e;

  localparam logic [2:0] MIN_G = 3'(MinGap);
  localparam logic [4:0] MAX_N = 5'(MaxPackets);

  period_e    st, st_d;
  logic [2:0] cnt, cnt_d;
  logic [4:0] slot, slot_d;
  logic [4:0] pidx, pidx_d;
  logic [4:0] n_lat, n_d;
  logic [2:0] gap, gap_d;
  logic [3:0] ctl_q, ctl_d;
  logic       ga_q, ga_d, gs_q, gs_d, ack_q, ack_d, ps_q, ps_d, ovr_q, ovr_d;

  logic [4:0]  n_clamp;
  logic [11:0] need;
  logic        accept;

  // Island must fit, plus the trailing control gap, before the next video preamble.
  always_comb begin
    n_clamp = (bus.island_len > MAX_N) ? MAX_N : bus.island_len;
    need    = 12'({n_clamp, 5'b00000}) + 12'd16;
    accept  = bus.island_req && !bus.video_next && (gap >= MIN_G) &&
              (bus.island_len != 5'd0) && (bus.blank_remaining >= need);
  end

  always_comb begin
    st_d   = st;
    cnt_d  = cnt;
    slot_d = slot;
    pidx_d = pidx;
    n_d    = n_lat;
    ovr_d  = ovr_q;
    case (st)
      P_CTRL: begin
        if (bus.video_next) begin
          st_d  = P_VPRE;
          cnt_d = 3'd0;
          if (gap < MIN_G) ovr_d = 1'b1;
        end else if (accept) begin
          st_d  = P_IPRE;
          cnt_d = 3'd0;
          n_d   = n_clamp;
        end
      end
      P_VPRE: begin
        if (bus.video_next) ovr_d = 1'b1;
        if (cnt == 3'd7) begin
          st_d  = P_VGUARD;
          cnt_d = 3'd0;
        end else begin
          cnt_d = cnt + 3'd1;
        end
      end
      P_VGUARD: begin
        if (bus.video_next) ovr_d = 1'b1;
        if (cnt == 3'd1) st_d = P_VACT;
        else             cnt_d = cnt + 3'd1;
      end
      P_VACT: begin
        if (bus.video_next) ovr_d = 1'b1;
        if (!bus.de_next) st_d = P_CTRL;
      end
      default: begin
        // Island states: a video_next here aborts the island outright.
        if (bus.video_next) begin
          st_d   = P_VPRE;
          cnt_d  = 3'd0;
          slot_d = 5'd0;
          pidx_d = 5'd0;
          ovr_d  = 1'b1;
        end else begin
          case (st)
            P_IPRE: begin
              if (cnt == 3'd7) begin
                st_d  = P_IGL;
                cnt_d = 3'd0;
              end else begin
                cnt_d = cnt + 3'd1;
              end
            end
            P_IGL: begin
              if (cnt == 3'd1) begin
                st_d   = P_IDATA;
                slot_d = 5'd0;
                pidx_d = 5'd0;
              end else begin
                cnt_d = cnt + 3'd1;
              end
            end
            P_IDATA: begin
              if (slot == 5'd31) begin
                slot_d = 5'd0;
                if (pidx == n_lat - 5'd1) begin
                  st_d   = P_IGT;
                  cnt_d  = 3'd0;
                  pidx_d = 5'd0;
                end else begin
                  pidx_d = pidx + 5'd1;
                end
              end else begin
                slot_d = slot + 5'd1;
              end
            end
            default: begin
              if (cnt == 3'd1) st_d = P_CTRL;
              else             cnt_d = cnt + 3'd1;
            end
          endcase
        end
      end
    endcase

    gap_d = (st_d == P_CTRL) ? ((gap == 3'd7) ? gap : gap + 3'd1) : 3'd0;
    ctl_d = (st_d == P_VPRE) ? 4'b0001 : (st_d == P_IPRE) ? 4'b0101 : 4'b0000;
    ga_d  = (st_d == P_VGUARD) || (st_d == P_IGL) || (st_d == P_IGT);
    gs_d  = (st_d == P_IGL) || (st_d == P_IGT);
    ack_d = (st == P_CTRL) && (st_d == P_IPRE);
    ps_d  = (st_d == P_IDATA) && (slot_d == 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= P_CTRL;
      cnt   <= 3'd0;
      slot  <= 5'd0;
      pidx  <= 5'd0;
      n_lat <= 5'd0;
      gap   <= 3'd0;
      ctl_q <= 4'd0;
      ga_q  <= 1'b0;
      gs_q  <= 1'b0;
      ack_q <= 1'b0;
      ps_q  <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      st    <= st_d;
      cnt   <= cnt_d;
      slot  <= slot_d;
      pidx  <= pidx_d;
      n_lat <= n_d;
      gap   <= gap_d;
      ctl_q <= ctl_d;
      ga_q  <= ga_d;
      gs_q  <= gs_d;
      ack_q <= ack_d;
      ps_q  <= ps_d;
      ovr_q <= ovr_d;
    end
  end

  assign bus.period       = st;
  assign bus.ctl          = ctl_q;
  assign bus.guard_active = ga_q;
  assign bus.guard_switch = gs_q;
  assign bus.island_ack   = ack_q;
  assign bus.packet_start = ps_q;
  assign bus.packet_index = pidx;
  assign bus.overrun      = ovr_q;

endmodule
